// File: rtl/mmu_arb_pkg.sv
`default_nettype none
// ============================================================================
// mmu_arb_pkg : shared types/constants for the MMU port arbiter   (rev 1.0)
// ============================================================================
package mmu_arb_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      I_AR = 3'd1,
      I_R  = 3'd2,
      D_AR = 3'd3,
      D_R  = 3'd4,
      D_AW = 3'd5,
      D_W  = 3'd6,
      D_B  = 3'd7
   } arb_state_t;

   // Bit positions of each requester class inside a one-hot grant vector
   localparam int unsigned CLS_I   = 0;
   localparam int unsigned CLS_DR  = 1;
   localparam int unsigned CLS_DW  = 2;
   localparam int unsigned NUM_CLS = 3;

   localparam logic [2:0] EXC_UNDEFINED = 3'b111;
   localparam logic [1:0] OKAY          = 2'b00;
   localparam logic [1:0] SLVERR        = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mmu_arb_pick.sv
`default_nettype none
// ============================================================================
// mmu_arb_pick : one-hot grant picker; round-robin under MMU_ARB_RR_EN (rev 1.0)
// ============================================================================
module mmu_arb_pick
   import mmu_arb_pkg::*;
(
   input  logic                 i_req_i,
   input  logic                 i_req_dr,
   input  logic                 i_req_dw,
   input  logic                 i_rr_ptr,
   output logic [NUM_CLS-1:0]   o_gnt
);

`ifdef MMU_ARB_RR_EN
   // i_rr_ptr high means ifetch was not the last class granted
   always_comb begin
      o_gnt = '0;
      if (i_rr_ptr && i_req_i)
         o_gnt[CLS_I] = 1'b1;
      else if (i_req_dr)
         o_gnt[CLS_DR] = 1'b1;
      else if (i_req_dw)
         o_gnt[CLS_DW] = 1'b1;
      else if (i_req_i)
         o_gnt[CLS_I] = 1'b1;
   end
`else
   logic w_unused_ptr;
   assign w_unused_ptr = i_rr_ptr;

   always_comb begin
      o_gnt = '0;
      if (i_req_dr)
         o_gnt[CLS_DR] = 1'b1;
      else if (i_req_dw)
         o_gnt[CLS_DW] = 1'b1;
      else if (i_req_i)
         o_gnt[CLS_I] = 1'b1;
   end
`endif

endmodule
`default_nettype wire

// File: rtl/mmu_arbiter.sv
`default_nettype none
// ============================================================================
// mmu_arbiter : shares the MMU AXI-lite slave between ifetch and LSU (rev 1.0)
// Optional round-robin between ifetch and data classes: MMU_ARB_RR_EN
// ============================================================================
module mmu_arbiter
   import mmu_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   // ifetch
   input  logic [31:0] i_araddr,
   input  logic        i_arvalid,
   output logic        i_arready,
   output logic [31:0] i_rdata,
   output logic [1:0]  i_rresp,
   output logic        i_rvalid,
   input  logic        i_rready,
   output logic        i_exc,
   output logic [2:0]  i_exc_vec,
   // load/store
   input  logic [31:0] d_araddr,
   input  logic        d_arvalid,
   output logic        d_arready,
   output logic [31:0] d_rdata,
   output logic [1:0]  d_rresp,
   output logic        d_rvalid,
   input  logic        d_rready,
   input  logic [31:0] d_awaddr,
   input  logic        d_awvalid,
   output logic        d_awready,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   input  logic        d_wvalid,
   output logic        d_wready,
   output logic [1:0]  d_bresp,
   output logic        d_bvalid,
   input  logic        d_bready,
   output logic        d_exc,
   output logic [2:0]  d_exc_vec,
   // MMU side
   output logic [31:0] m_araddr,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rvalid,
   output logic        m_rready,
   output logic [31:0] m_awaddr,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   input  logic [1:0]  m_bresp,
   input  logic        m_bvalid,
   output logic        m_bready,
   output logic        is_instr,
   input  logic        throw_exception,
   input  logic [2:0]  exception_vec
);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [NUM_CLS-1:0]  w_gnt;
   logic                r_rr_ptr;
   logic                r_i_arready;
   logic                r_d_arready;
   logic                r_d_awready;
   logic [31:0]         r_m_araddr;
   logic [31:0]         r_m_awaddr;
   logic                r_m_arvalid;
   logic                r_m_awvalid;
   logic                r_is_instr;

   mmu_arb_pick u_pick (
      .i_req_i  (i_arvalid),
      .i_req_dr (d_arvalid),
      .i_req_dw (d_awvalid),
      .i_rr_ptr (r_rr_ptr),
      .o_gnt    (w_gnt)
   );

   always_ff @(posedge clk) begin
      if (!rstn)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_gnt[CLS_I])
               w_state_nxt = I_AR;
            else if (w_gnt[CLS_DR])
               w_state_nxt = D_AR;
            else if (w_gnt[CLS_DW])
               w_state_nxt = D_AW;
         end
         I_AR: if (m_arready) w_state_nxt = I_R;
         D_AR: if (m_arready) w_state_nxt = D_R;
         I_R:  if (m_rvalid && i_rready) w_state_nxt = IDLE;
         D_R:  if (m_rvalid && d_rready) w_state_nxt = IDLE;
         D_AW: if (m_awready) w_state_nxt = D_W;
         D_W:  if (d_wvalid && m_wready) w_state_nxt = D_B;
         D_B:  if (m_bvalid && d_bready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Grant-side registers; ready pulses default low so each lasts one cycle
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_i_arready <= 1'b0;
         r_d_arready <= 1'b0;
         r_d_awready <= 1'b0;
         r_m_araddr  <= '0;
         r_m_awaddr  <= '0;
         r_m_arvalid <= 1'b0;
         r_m_awvalid <= 1'b0;
         r_is_instr  <= 1'b0;
         r_rr_ptr    <= 1'b0;
      end else begin
         r_i_arready <= 1'b0;
         r_d_arready <= 1'b0;
         r_d_awready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_gnt[CLS_I]) begin
                  r_i_arready <= 1'b1;
                  r_m_araddr  <= i_araddr;
                  r_m_arvalid <= 1'b1;
                  r_is_instr  <= 1'b1;
                  r_rr_ptr    <= 1'b0;
               end else if (w_gnt[CLS_DR]) begin
                  r_d_arready <= 1'b1;
                  r_m_araddr  <= d_araddr;
                  r_m_arvalid <= 1'b1;
                  r_rr_ptr    <= 1'b1;
               end else if (w_gnt[CLS_DW]) begin
                  r_d_awready <= 1'b1;
                  r_m_awaddr  <= d_awaddr;
                  r_m_awvalid <= 1'b1;
                  r_rr_ptr    <= 1'b1;
               end
            end
            I_AR, D_AR: if (m_arready) r_m_arvalid <= 1'b0;
            D_AW:       if (m_awready) r_m_awvalid <= 1'b0;
            I_R:        if (m_rvalid && i_rready) r_is_instr <= 1'b0;
            default: ;
         endcase
      end
   end

   assign i_arready = r_i_arready;
   assign d_arready = r_d_arready;
   assign d_awready = r_d_awready;
   assign m_araddr  = r_m_araddr;
   assign m_awaddr  = r_m_awaddr;
   assign m_arvalid = r_m_arvalid;
   assign m_awvalid = r_m_awvalid;
   assign is_instr  = r_is_instr;

   always_comb begin
      i_rdata   = '0;
      i_rresp   = '0;
      i_rvalid  = 1'b0;
      i_exc     = 1'b0;
      i_exc_vec = '0;
      d_rdata   = '0;
      d_rresp   = '0;
      d_rvalid  = 1'b0;
      d_wready  = 1'b0;
      d_bresp   = '0;
      d_bvalid  = 1'b0;
      d_exc     = 1'b0;
      d_exc_vec = '0;
      m_rready  = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      case (r_state)
         I_R: begin
            i_rdata   = m_rdata;
            i_rresp   = m_rresp;
            i_rvalid  = m_rvalid;
            m_rready  = i_rready;
            i_exc     = throw_exception & m_rvalid;
            i_exc_vec = exception_vec;
         end
         D_R: begin
            d_rdata   = m_rdata;
            d_rresp   = m_rresp;
            d_rvalid  = m_rvalid;
            m_rready  = d_rready;
            d_exc     = throw_exception & m_rvalid;
            d_exc_vec = exception_vec;
         end
         D_W: begin
            m_wdata   = d_wdata;
            m_wstrb   = d_wstrb;
            m_wvalid  = d_wvalid;
            d_wready  = m_wready;
         end
         D_B: begin
            d_bresp   = m_bresp;
            d_bvalid  = m_bvalid;
            m_bready  = d_bready;
            d_exc     = throw_exception & m_bvalid;
            d_exc_vec = exception_vec;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mmu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mmu_arbiter : directed self-checking bench for mmu_arbiter       (rev 1.0)
// ============================================================================
module tb_mmu_arbiter;
   import mmu_arb_pkg::*;

   logic        clk;
   logic        rstn;
   logic [31:0] i_araddr;
   logic        i_arvalid, i_arready;
   logic [31:0] i_rdata;
   logic [1:0]  i_rresp;
   logic        i_rvalid, i_rready, i_exc;
   logic [2:0]  i_exc_vec;
   logic [31:0] d_araddr;
   logic        d_arvalid, d_arready;
   logic [31:0] d_rdata;
   logic [1:0]  d_rresp;
   logic        d_rvalid, d_rready;
   logic [31:0] d_awaddr;
   logic        d_awvalid, d_awready;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_wvalid, d_wready;
   logic [1:0]  d_bresp;
   logic        d_bvalid, d_bready, d_exc;
   logic [2:0]  d_exc_vec;
   logic [31:0] m_araddr;
   logic        m_arvalid, m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid, m_rready;
   logic [31:0] m_awaddr;
   logic        m_awvalid, m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid, m_wready;
   logic [1:0]  m_bresp;
   logic        m_bvalid, m_bready;
   logic        is_instr, throw_exception;
   logic [2:0]  exception_vec;

   int n_assert = 0;
   int n_fail   = 0;
   int n_aw_hs  = 0;
   int n_w_hs   = 0;

   mmu_arbiter dut (
      .clk(clk), .rstn(rstn),
      .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rready(i_rready),
      .i_exc(i_exc), .i_exc_vec(i_exc_vec),
      .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
      .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
      .d_awaddr(d_awaddr), .d_awvalid(d_awvalid), .d_awready(d_awready),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
      .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
      .d_exc(d_exc), .d_exc_vec(d_exc_vec),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .is_instr(is_instr), .throw_exception(throw_exception), .exception_vec(exception_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_awvalid && m_awready) n_aw_hs <= n_aw_hs + 1;
      if (m_wvalid && m_wready)   n_w_hs  <= n_w_hs + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [2:0]  g;
   logic [2:0]  exp_ord [3];
   logic [31:0] exp_addr;
   int          aw0, w0;

   initial begin
`ifdef MMU_ARB_RR_EN
      exp_ord = '{3'b010, 3'b001, 3'b100};  // DR, I, DW
`else
      exp_ord = '{3'b010, 3'b100, 3'b001};  // DR, DW, I
`endif
      rstn = 1'b0;
      i_araddr = '0; i_arvalid = 0; i_rready = 0;
      d_araddr = '0; d_arvalid = 0; d_rready = 0;
      d_awaddr = '0; d_awvalid = 0; d_wdata = '0; d_wstrb = '0; d_wvalid = 0; d_bready = 0;
      m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
      m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
      throw_exception = 0; exception_vec = '0;
      cyc(); cyc(); cyc();
      chk("rst_i_arready", 32'(i_arready), 0);
      chk("rst_m_arvalid", 32'(m_arvalid), 0);
      chk("rst_m_awvalid", 32'(m_awvalid), 0);
      chk("rst_m_araddr", m_araddr, 0);
      chk("rst_is_instr", 32'(is_instr), 0);
      rstn = 1'b1;
      cyc();

      // lone ifetch, MMU ready one cycle late
      i_araddr = 32'h0000_1000; i_arvalid = 1; i_rready = 1;
      cyc();
      chk("if_arready", 32'(i_arready), 1);
      chk("if_m_arvalid", 32'(m_arvalid), 1);
      chk("if_m_araddr", m_araddr, 32'h0000_1000);
      chk("if_is_instr_grant", 32'(is_instr), 1);
      chk("if_d_arready", 32'(d_arready), 0);
      cyc();
      chk("if_arready_pulse", 32'(i_arready), 0);
      chk("if_m_arvalid_hold", 32'(m_arvalid), 1);
      i_arvalid = 0; m_arready = 1;
      cyc();
      m_arready = 0;
      chk("if_m_arvalid_clr", 32'(m_arvalid), 0);
      chk("if_is_instr_mid", 32'(is_instr), 1);
      m_rdata = 32'hDEAD_BEEF; m_rresp = OKAY; m_rvalid = 1;
      #1;
      chk("if_rdata", i_rdata, 32'hDEAD_BEEF);
      chk("if_rvalid", 32'(i_rvalid), 1);
      chk("if_m_rready", 32'(m_rready), 1);
      chk("if_d_rvalid", 32'(d_rvalid), 0);
      chk("if_d_bvalid", 32'(d_bvalid), 0);
      chk("if_is_instr_hs", 32'(is_instr), 1);
      cyc();
      m_rvalid = 0;
      #1;
      chk("if_is_instr_done", 32'(is_instr), 0);
      chk("if_rvalid_done", 32'(i_rvalid), 0);

      // data write
      aw0 = n_aw_hs; w0 = n_w_hs;
      d_awaddr = 32'h0000_0040; d_awvalid = 1;
      d_wdata = 32'h1122_3344; d_wstrb = 4'hF; d_wvalid = 1; d_bready = 1;
      cyc();
      chk("wr_awready", 32'(d_awready), 1);
      chk("wr_m_awvalid", 32'(m_awvalid), 1);
      chk("wr_m_awaddr", m_awaddr, 32'h0000_0040);
      chk("wr_is_instr", 32'(is_instr), 0);
      m_awready = 1;
      cyc();
      d_awvalid = 0; m_awready = 0;
      chk("wr_m_awvalid_clr", 32'(m_awvalid), 0);
      chk("wr_m_wvalid", 32'(m_wvalid), 1);
      chk("wr_m_wdata", m_wdata, 32'h1122_3344);
      chk("wr_m_wstrb", 32'(m_wstrb), 32'hF);
      m_wready = 1;
      #1;
      chk("wr_d_wready", 32'(d_wready), 1);
      cyc();
      d_wvalid = 0; m_wready = 0;
      m_bresp = OKAY; m_bvalid = 1;
      #1;
      chk("wr_d_bvalid", 32'(d_bvalid), 1);
      chk("wr_d_bresp", 32'(d_bresp), 32'(OKAY));
      chk("wr_m_bready", 32'(m_bready), 1);
      cyc();
      m_bvalid = 0;
      #1;
      chk("wr_d_bvalid_done", 32'(d_bvalid), 0);
      chk("wr_aw_hs_count", 32'(n_aw_hs - aw0), 1);
      chk("wr_w_hs_count", 32'(n_w_hs - w0), 1);

      // data read with MMU error + exception
      d_araddr = 32'h0000_0080; d_arvalid = 1; d_rready = 1;
      cyc();
      chk("rd_arready", 32'(d_arready), 1);
      chk("rd_m_araddr", m_araddr, 32'h0000_0080);
      m_arready = 1;
      cyc();
      d_arvalid = 0; m_arready = 0;
      m_rdata = '0; m_rresp = SLVERR; m_rvalid = 1;
      throw_exception = 1; exception_vec = EXC_UNDEFINED;
      #1;
      chk("rd_d_exc", 32'(d_exc), 1);
      chk("rd_d_exc_vec", 32'(d_exc_vec), 32'(EXC_UNDEFINED));
      chk("rd_d_rresp", 32'(d_rresp), 32'(SLVERR));
      chk("rd_d_rvalid", 32'(d_rvalid), 1);
      chk("rd_i_exc", 32'(i_exc), 0);
      chk("rd_i_rvalid", 32'(i_rvalid), 0);
      cyc();
      m_rvalid = 0; throw_exception = 0; exception_vec = '0;

      // three simultaneous requests from a fresh reset
      rstn = 0;
      cyc();
      rstn = 1;
      i_araddr = 32'h0000_2000; d_araddr = 32'h0000_3000; d_awaddr = 32'h0000_4000;
      i_arvalid = 1; d_arvalid = 1; d_awvalid = 1;
      d_wvalid = 1; i_rready = 1; d_rready = 1; d_bready = 1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         g = {d_awready, d_arready, i_arready};
         chk($sformatf("ord_grant_%0d", k), 32'(g), 32'(exp_ord[k]));
         chk($sformatf("ord_is_instr_%0d", k), 32'(is_instr), 32'(g[CLS_I]));
         if (g[CLS_I] || g[CLS_DR]) begin
            exp_addr = g[CLS_I] ? 32'h0000_2000 : 32'h0000_3000;
            chk($sformatf("ord_araddr_%0d", k), m_araddr, exp_addr);
            m_arready = 1;
            cyc();
            if (g[CLS_I]) i_arvalid = 0; else d_arvalid = 0;
            m_arready = 0; m_rvalid = 1;
            cyc();
            m_rvalid = 0;
         end else if (g[CLS_DW]) begin
            chk($sformatf("ord_awaddr_%0d", k), m_awaddr, 32'h0000_4000);
            m_awready = 1;
            cyc();
            d_awvalid = 0; m_awready = 0; m_wready = 1;
            cyc();
            m_wready = 0; m_bvalid = 1;
            cyc();
            m_bvalid = 0;
         end
      end
      i_arvalid = 0; d_arvalid = 0; d_awvalid = 0; d_wvalid = 0;
      cyc();

      // reset while waiting in D_R
      d_araddr = 32'h0000_0500; d_arvalid = 1; d_rready = 1;
      cyc();
      m_arready = 1;
      cyc();
      d_arvalid = 0; m_arready = 0;
      rstn = 0;
      cyc();
      m_rvalid = 1;
      #1;
      chk("rst_mid_d_rvalid", 32'(d_rvalid), 0);
      chk("rst_mid_m_rready", 32'(m_rready), 0);
      chk("rst_mid_m_arvalid", 32'(m_arvalid), 0);
      chk("rst_mid_m_araddr", m_araddr, 0);
      chk("rst_mid_d_arready", 32'(d_arready), 0);
      m_rvalid = 0;
      rstn = 1;
      i_araddr = 32'h0000_0600; i_arvalid = 1;
      cyc();
      chk("rst_after_i_arready", 32'(i_arready), 1);
      chk("rst_after_is_instr", 32'(is_instr), 1);
      chk("rst_after_m_araddr", m_araddr, 32'h0000_0600);
      i_arvalid = 0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mmu_arbiter.md
# mmu_arbiter

Shares the MMU's single core-side AXI-lite slave port between the instruction-fetch unit (read-only) and the load/store unit (read and write). It allows one transaction in flight at a time. It drives the MMU's `is_instr` qualifier for the whole transaction and routes the response and the MMU exception flags back to the requester that owns the grant. It sits between the core's two memory requesters and `mmu`.

## Interface
Parameters:
- none (all widths fixed: 32-bit address/data, 4-bit strobe, 2-bit resp, 3-bit exception vector)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_araddr / i_arvalid / i_arready  in/in/out  32/1/1  ifetch read address channel
- i_rdata / i_rresp / i_rvalid / i_rready  out/out/out/in  32/2/1/1  ifetch read data channel
- i_exc / i_exc_vec  out/out  1/3  ifetch exception, valid with i_rvalid
- d_araddr / d_arvalid / d_arready  in/in/out  32/1/1  data read address
- d_rdata / d_rresp / d_rvalid / d_rready  out/out/out/in  32/2/1/1  data read response
- d_awaddr / d_awvalid / d_awready  in/in/out  32/1/1  data write address
- d_wdata / d_wstrb / d_wvalid / d_wready  in/in/in/out  32/4/1/1  data write data
- d_bresp / d_bvalid / d_bready  out/out/in  2/1/1  data write response
- d_exc / d_exc_vec  out/out  1/3  data exception, valid with d_rvalid or d_bvalid
- m_araddr / m_arvalid / m_arready  out/out/in  32/1/1  to MMU read address
- m_rdata / m_rresp / m_rvalid / m_rready  in/in/in/out  32/2/1/1  from MMU read data
- m_awaddr / m_awvalid / m_awready  out/out/in  32/1/1  to MMU write address
- m_wdata / m_wstrb / m_wvalid / m_wready  out/out/out/in  32/4/1/1  to MMU write data
- m_bresp / m_bvalid / m_bready  in/in/out  2/1/1  from MMU write response
- is_instr  out  1  high for the whole duration of an ifetch transaction
- throw_exception / exception_vec  in/in  1/3  from MMU

## Operation
- States: IDLE, I_AR, I_R, D_AR, D_R, D_AW, D_W, D_B.
- IDLE: pick one pending request from i_arvalid, d_arvalid and d_awvalid using the priority rule (see Configuration).
  - The winner's arready/awready is registered high for exactly one cycle.
  - The winner's address is latched into m_araddr or m_awaddr, and m_arvalid or m_awvalid is set.
  - Go to I_AR, D_AR or D_AW.
  - On an ifetch grant, is_instr is set in the same cycle.
- x_AR / D_AW: hold m_*valid until m_*ready is high. In that cycle clear valid and go to x_R or D_W.
- I_R / D_R: pass-through.
  - m_rdata, m_rresp and m_rvalid are routed to the owner's r channel.
  - m_rready equals the owner's rready.
  - x_exc = throw_exception & m_rvalid, and x_exc_vec = exception_vec.
  - On m_rvalid & rready: go to IDLE and clear is_instr.
- D_W: pass-through. m_wdata, m_wstrb and m_wvalid come from the d_w channel, and d_wready = m_wready. On the handshake go to D_B.
- D_B: pass-through of the b channel plus d_exc. On the m_bvalid & d_bready handshake go to IDLE.
- The non-owner's response valids stay 0. Its arready/awready stay 0 until it is granted.
- A requester must hold valid and address until its ready pulse. The arbiter never drops a pending request.

## Timing
- Reset values:
  - All ready pulses, m_arvalid, m_awvalid and is_instr are 0.
  - m_araddr and m_awaddr are 0.
  - State is IDLE, and the round-robin pointer favours data.
  - Pass-through outputs are 0 outside their owning state.
- Latency:
  - Request seen in IDLE → m_*valid high the next cycle.
  - Response handshake → IDLE. A new grant can be issued one cycle after returning to IDLE.
  - Minimum spacing between back-to-back transactions is 2 cycles plus MMU latency.
- Simultaneous d_arvalid and d_awvalid: the read is served first. The write waits.
- The MMU's arready/awready alternate, and the arbiter tolerates ready arriving any number of cycles after valid.
- is_instr is stable from grant through the final response handshake, because the MMU samples it during translation.
- Reset mid-transaction: return to IDLE next edge and drop the transaction. The MMU and requesters are reset by the same rstn.

## Configuration
- MMU_ARB_RR_EN defined:
  - Round-robin between the ifetch class and the data class.
  - The class granted last has lowest priority at the next IDLE arbitration.
  - Within the data class, read is served before write.
- Undefined: fixed priority of data read > data write > ifetch. Ifetch can starve under continuous data traffic.

## Structure
- Package mmu_arb_pkg:
  - State enum.
  - Requester-class encoding (CLS_I, CLS_DR, CLS_DW).
  - EXC_UNDEFINED = 3'b111.
  - Response codes OKAY = 2'b00 and SLVERR = 2'b10.
- Sub-module mmu_arb_pick:
  - Combinational picker.
  - Inputs: the three requests and the round-robin pointer.
  - Outputs: a one-hot grant.
  - The round-robin logic is under the macro.

## Test plan
- Lone ifetch at 0x00001000; MMU returns 0xDEADBEEF OKAY → i_rdata=0xDEADBEEF, is_instr high from grant to handshake, d_* valids stay 0.
- d_awvalid with awaddr=0x00000040, wdata=0x11223344, wstrb=4'hF; MMU bresp=OKAY → exactly one m_aw and one m_w handshake, d_bvalid=1, is_instr=0.
- MMU rresp=2'b10 with throw_exception=1, exception_vec=3'b111 on a data read → d_exc=1, d_exc_vec=3'b111, d_rresp=2'b10, i_exc=0.
- i_arvalid, d_arvalid and d_awvalid asserted together and held:
  - Without MMU_ARB_RR_EN → grant order DR, DW, I.
  - With the macro → grant order DR, I, DW.
- rstn pulled low while in D_R with m_rvalid=0 → next cycle state IDLE, all outputs at reset values, and a new ifetch is granted after rstn is released.
